// File: rtl/mult_pkg.sv
// Shared definitions for the signed shift-add multiplier datapath:
// operand width and the decoded command encoding.
package mult_pkg;

    localparam int MULT_WIDTH = 8;

    // One decoded command per cycle, after priority resolution of the strobes.
    typedef enum logic [2:0] {
        OP_NONE,
        OP_CLRLD,
        OP_ADD,
        OP_SUB,
        OP_SHIFT
    } op_t;

endpackage

// File: rtl/mult_datapath_if.sv
// Command/operand bus between the multiplier control FSM (master) and
// the register datapath (slave).
interface mult_datapath_if
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
);
    logic             Clr_Ld;
    logic             Shift;
    logic             Add;
    logic             Sub;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] Aval;
    logic [WIDTH-1:0] Bval;
    logic             Xval;
    logic             M;
    logic             Done;

    modport master (
        output Clr_Ld, Shift, Add, Sub, S,
        input  Aval, Bval, Xval, M, Done
    );

    modport slave (
        input  Clr_Ld, Shift, Add, Sub, S,
        output Aval, Bval, Xval, M, Done
    );
endinterface

// File: rtl/mult_datapath_add_sub9.sv
// Combinational sign-extended adder used for both Add and Sub:
// subtraction inverts the b operand and injects a carry-in of 1.
module add_sub9 #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         inv_b,
    input  logic         cin,
    output logic [W-1:0] sum
);
    logic [W-1:0] b_eff;

    // Conditionally complement the second operand; carry wraps out of the top bit.
    always_comb begin
        b_eff = inv_b ? ~b : b;
        sum   = a + b_eff + W'(cin);
    end
endmodule

// File: rtl/mult_datapath.sv
// X/A/B register chain of the 8-bit signed shift-add multiplier.
// Executes Clr_Ld > Sub > Add > Shift strobes from the control FSM.
// Optional feature: define MULT_DP_SHIFTCNT_EN to build the shift counter
// that drives Done; otherwise Done is constant 0.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic            Clk,
    input  logic            Reset,
    mult_datapath_if.slave  bus
);
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic             x_reg, x_next;
    logic [WIDTH:0]   sum;
    logic             is_sub;
    op_t              op;

    // Priority decode: a higher-priority strobe masks all lower ones.
    always_comb begin
        op = OP_NONE;
        if (bus.Clr_Ld)     op = OP_CLRLD;
        else if (bus.Sub)   op = OP_SUB;
        else if (bus.Add)   op = OP_ADD;
        else if (bus.Shift) op = OP_SHIFT;
    end

    assign is_sub = (op == OP_SUB);

    add_sub9 #(.W(WIDTH + 1)) u_add_sub (
        .a     ({a_reg[WIDTH-1], a_reg}),
        .b     ({bus.S[WIDTH-1], bus.S}),
        .inv_b (is_sub),
        .cin   (is_sub),
        .sum   (sum)
    );

    // Next-state of the X:A:B chain; everything holds when no strobe wins.
    always_comb begin
        a_next = a_reg;
        b_next = b_reg;
        x_next = x_reg;
        case (op)
            OP_CLRLD: begin
                a_next = '0;
                x_next = 1'b0;
                b_next = bus.S;
            end
            OP_ADD, OP_SUB: begin
                a_next = sum[WIDTH-1:0];
                x_next = sum[WIDTH];
            end
            OP_SHIFT: begin
                a_next = {x_reg, a_reg[WIDTH-1:1]};
                b_next = {a_reg[0], b_reg[WIDTH-1:1]};
            end
            default: ;
        endcase
    end

    // Register chain with asynchronous clear.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            a_reg <= '0;
            b_reg <= '0;
            x_reg <= 1'b0;
        end else begin
            a_reg <= a_next;
            b_reg <= b_next;
            x_reg <= x_next;
        end
    end

    assign bus.Aval = a_reg;
    assign bus.Bval = b_reg;
    assign bus.Xval = x_reg;
    assign bus.M    = b_reg[0];

`ifdef MULT_DP_SHIFTCNT_EN
    localparam int                CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(WIDTH);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             done_reg;

    // Count executed shifts since the last load, saturating at WIDTH.
    always_comb begin
        cnt_next = cnt_reg;
        if (op == OP_CLRLD)
            cnt_next = '0;
        else if (op == OP_SHIFT && cnt_reg != CNT_MAX)
            cnt_next = cnt_reg + CNT_W'(1);
    end

    // Counter and registered Done flag, cleared with the datapath.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            done_reg <= (cnt_next == CNT_MAX);
        end
    end

    assign bus.Done = done_reg;
`else
    assign bus.Done = 1'b0;
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath: directed and random command
// streams compared against an arithmetic model of the X:A:B chain.
module tb_mult_datapath;
    import mult_pkg::*;

    localparam logic [3:0] ST_NONE = 4'b0000;
    localparam logic [3:0] ST_CLR  = 4'b1000;
    localparam logic [3:0] ST_SUB  = 4'b0100;
    localparam logic [3:0] ST_ADD  = 4'b0010;
    localparam logic [3:0] ST_SHF  = 4'b0001;

    logic Clk;
    logic Reset;

    mult_datapath_if #(.WIDTH(MULT_WIDTH)) bus ();

    mult_datapath #(.WIDTH(MULT_WIDTH)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Reference state: X, A, B as plain integers plus a shift count.
    int ma = 0, mb = 0, mx = 0, mcnt = 0;

    function automatic int sx8(input int v);
        return (v > 127) ? v - 256 : v;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic check_outs(input string tag);
        logic exp_done;
`ifdef MULT_DP_SHIFTCNT_EN
        exp_done = (mcnt == 8);
`else
        exp_done = 1'b0;
`endif
        chk({tag, ".A"},    {8'h00, bus.Aval}, 16'(ma));
        chk({tag, ".B"},    {8'h00, bus.Bval}, 16'(mb));
        chk({tag, ".X"},    {15'h0, bus.Xval}, 16'(mx));
        chk({tag, ".M"},    {15'h0, bus.M},    16'(mb & 1));
        chk({tag, ".Done"}, {15'h0, bus.Done}, {15'h0, exp_done});
    endtask

    // Model one clock edge from the arithmetic meaning of each command.
    task automatic model_step(input logic [3:0] stb, input logic [7:0] s, output op_t op);
        int r, v;
        op = OP_NONE;
        if (stb[3])      op = OP_CLRLD;
        else if (stb[2]) op = OP_SUB;
        else if (stb[1]) op = OP_ADD;
        else if (stb[0]) op = OP_SHIFT;
        case (op)
            OP_CLRLD: begin ma = 0; mx = 0; mb = int'(s); mcnt = 0; end
            OP_ADD: begin
                r  = sx8(ma) + sx8(int'(s));
                ma = r & 255; mx = (r >> 8) & 1;
            end
            OP_SUB: begin
                r  = sx8(ma) - sx8(int'(s));
                ma = r & 255; mx = (r >> 8) & 1;
            end
            OP_SHIFT: begin
                v  = (mx != 0 ? -65536 : 0) + ma * 256 + mb;
                v  = v >>> 1;
                ma = (v >>> 8) & 255; mb = v & 255;
                if (mcnt < 8) mcnt++;
            end
            default: ;
        endcase
    endtask

    task automatic do_op(input logic [3:0] stb, input logic [7:0] s, input string tag);
        op_t op;
        bus.Clr_Ld = stb[3]; bus.Sub = stb[2]; bus.Add = stb[1]; bus.Shift = stb[0];
        bus.S = s;
        @(posedge Clk);
        #1;
        bus.Clr_Ld = 1'b0; bus.Sub = 1'b0; bus.Add = 1'b0; bus.Shift = 1'b0;
        model_step(stb, s, op);
        $display("%s op=%s S=%02h -> A=%02h B=%02h X=%0d M=%0d Done=%0d",
                 tag, op.name(), s, bus.Aval, bus.Bval, bus.Xval, bus.M, bus.Done);
        check_outs(tag);
    endtask

    // Drive the FSM's expected sequence and compare A:B against b*s.
    task automatic full_seq(input logic [7:0] b, input logic [7:0] s, input string tag);
        int p;
        do_op(ST_CLR, b, {tag, ".ld"});
        for (int i = 0; i < 7; i++) begin
            if ((mb & 1) != 0) do_op(ST_ADD, s, {tag, ".add"});
            do_op(ST_SHF, s, {tag, ".shf"});
        end
        if ((mb & 1) != 0) do_op(ST_SUB, s, {tag, ".sub"});
        do_op(ST_SHF, s, {tag, ".shf"});
        p = sx8(int'(b)) * sx8(int'(s));
        chk({tag, ".prod"}, {bus.Aval, bus.Bval}, 16'(p));
        chk({tag, ".sign"}, {15'h0, bus.Xval}, {15'h0, (p < 0)});
    endtask

    initial begin
        Reset = 1'b0;
        bus.Clr_Ld = 1'b0; bus.Sub = 1'b0; bus.Add = 1'b0; bus.Shift = 1'b0;
        bus.S = 8'h00;

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        check_outs("reset");
        Reset = 1'b1;

        // Single ops from the plan
        do_op(ST_CLR, 8'h00, "add.ld");
        do_op(ST_ADD, 8'h7F, "add.pre");
        do_op(ST_ADD, 8'h01, "add");
        chk("add.A80", {8'h00, bus.Aval}, 16'h0080);
        do_op(ST_CLR, 8'h00, "sub.ld");
        do_op(ST_SUB, 8'h01, "sub");
        chk("sub.AFF", {8'h00, bus.Aval}, 16'h00FF);
        chk("sub.X1",  {15'h0, bus.Xval}, 16'h0001);
        do_op(ST_CLR, 8'h01, "shf.ld");
        do_op(ST_ADD, 8'h80, "shf.pre");
        do_op(ST_SHF, 8'h00, "shf");
        chk("shf.AB", {bus.Aval, bus.Bval}, 16'hC000);

        // Full multiplications from the plan
        full_seq(8'h07, 8'h3B, "m413");
        chk("m413.AB", {bus.Aval, bus.Bval}, 16'h019D);
        full_seq(8'h07, 8'hC5, "mneg413");
        chk("mneg413.AB", {bus.Aval, bus.Bval}, 16'hFE63);
        full_seq(8'h80, 8'h80, "m16384");
        chk("m16384.AB", {bus.Aval, bus.Bval}, 16'h4000);

        // Simultaneous strobes: load wins
        do_op(ST_CLR | ST_ADD | ST_SHF, 8'h12, "prio");
        chk("prio.B12", {8'h00, bus.Bval}, 16'h0012);

        // Idle cycle holds everything
        do_op(ST_NONE, 8'hAA, "hold");

        // Shift counter: 8 shifts, a 9th, then reload
        do_op(ST_CLR, 8'h5C, "cnt.ld");
        for (int i = 0; i < 9; i++) do_op(ST_SHF, 8'h00, "cnt.shf");
        do_op(ST_CLR, 8'h01, "cnt.clr");

        // Random multiplications
        for (int i = 0; i < 12; i++)
            full_seq(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rmul");

        // Random strobe combinations with random operands
        for (int i = 0; i < 60; i++)
            do_op(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), "rnd");

        // Reset asserted in the middle of a Shift cycle
        do_op(ST_CLR, 8'hC3, "mid.ld");
        do_op(ST_ADD, 8'h5A, "mid.pre");
        bus.Shift = 1'b1;
        #2;
        Reset = 1'b0;
        #1;
        ma = 0; mb = 0; mx = 0; mcnt = 0;
        check_outs("rst_async");
        bus.Shift = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check_outs("rst_release");

        // Back-to-back traffic after reset
        full_seq(8'h07, 8'h3B, "post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_datapath.md
# mult_datapath

Register and arithmetic datapath for the 8-bit signed shift-add multiplier. Sits directly downstream of the multiplier control FSM and executes its one-hot-style command strobes (Clr_Ld, Shift, Add, Sub) on the X/A/B register chain. Returns the multiplier LSB (M) to the FSM and drives the product registers to the hex displays and LEDs.

## Interface
- WIDTH, 8: operand width; A, B and S are WIDTH bits, adder is WIDTH+1.
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Clr_Ld  in  1  clear A and X, load B from S.
- Shift  in  1  arithmetic right shift of X:A:B.
- Add  in  1  A <= A + S, X <= sum sign.
- Sub  in  1  A <= A - S, X <= difference sign.
- S  in  WIDTH  switch operand; multiplier on load, multiplicand on Add/Sub.
- Aval  out  WIDTH  A register, product high byte.
- Bval  out  WIDTH  B register, product low byte.
- Xval  out  1  sign-extension bit X.
- M  out  1  B[0], combinational from register, fed to the FSM.
- Done  out  1  eight shifts completed since last Clr_Ld; tied 0 when the counter is compiled out.

## Operation
- Command priority on each edge: Clr_Ld > Sub > Add > Shift. Lower-priority strobes asserted in the same cycle are ignored. No strobe asserted: all registers hold.
- Clr_Ld: A <= 0, X <= 0, B <= S.
- Add: form 9-bit sum {A[7],A} + {S[7],S}, A <= sum[7:0], X <= sum[8].
- Sub: same as Add with the operand replaced by ~{S[7],S} and carry-in 1. No separate subtractor.
- Shift: X holds, A <= {X, A[7:1]}, B <= {A[0], B[7:1]}.
- Overflow beyond 9 bits is discarded, with no saturation and no flag.
- S is not registered. Its value is used only in the cycle of the strobe that consumes it.
- Expected FSM sequence: Clr_Ld, then 7 × (Add if M; Shift), then (Sub if M; Shift). After that, X:A:B holds the signed 16-bit product in A:B, and X equals the product sign.

## Timing
- All register updates happen on the rising Clk edge where the strobe is sampled high. The result is visible on Aval/Bval/Xval/M one cycle later.
- M follows B[0] combinationally, so the FSM sees the new M in the cycle after a Shift, with no extra latency.
- Reset low, at any time and including mid-operation: A, B, X and the shift counter go to 0 immediately. Aval=0x00, Bval=0x00, Xval=0, M=0, Done=0. Release is synchronous to the next edge, with no partial state retained.
- One operation per cycle. Back-to-back Add then Shift on consecutive cycles is required to work.

## Configuration
- MULT_DP_SHIFTCNT_EN defined:
  - 4-bit shift counter is cleared by Clr_Ld and incremented on each executed Shift.
  - Counter saturates at 8 and does not wrap.
  - Done = (count == 8), registered.
  - Further Shifts still execute; only Done stays high.
- Not defined: no counter logic; Done is constant 0.

## Structure
- Package mult_pkg holds:
  - localparam MULT_WIDTH = 8.
  - typedef enum for the decoded op (OP_NONE, OP_CLRLD, OP_ADD, OP_SUB, OP_SHIFT), used by the priority decoder and the bench.
- One sub-module: add_sub9, a combinational 9-bit adder with an invert-B input and carry-in.
- Registers and the priority decode stay in mult_datapath.

## Test plan
- Reset low mid-Shift with A=0x5A, B=0xC3 -> all outputs 0 immediately. Registers stay 0 for the first edge after release when no strobe is asserted.
- Single ops:
  - A=0x7F, S=0x01, Add -> A=0x80, X=0.
  - A=0x00, S=0x01, Sub -> A=0xFF, X=1.
  - X=1, A=0x80, B=0x01, Shift -> A=0xC0, B=0x00, X=1, M=0.
- Full sequence, B loaded 0x07, then S=0x3B -> A=0x01, B=0x9D, X=0 (413).
- Full sequence, B loaded 0x07, then S=0xC5 -> A=0xFE, B=0x63, X=1 (-413).
- Full sequence, B loaded 0x80, then S=0x80 (Sub step taken) -> A=0x40, B=0x00, X=0 (16384).
- Clr_Ld+Add+Shift asserted together with S=0x12 -> only load: A=0, X=0, B=0x12.
- With MULT_DP_SHIFTCNT_EN: Done rises one cycle after the 8th Shift, stays 1 on a 9th Shift, and clears on Clr_Ld.
